// File: rtl/boot_sequencer.sv
// Boot sequencer: resets and runs the EEPROM-to-RAM copier, then hands the
// shared memory bus to the CPU and releases CPU reset. A copy that never
// finishes parks the system in ERROR with the CPU held in reset.
module boot_sequencer #(
    parameter int unsigned SETTLE_CYCLES       = 4,
    parameter int unsigned CPU_RESET_CYCLES    = 16,
    parameter int unsigned COPY_TIMEOUT_CYCLES = 40000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reboot_req,
    input  logic        copier_done,
    input  logic [15:0] copier_address,
    input  logic        copier_ram_we_n,
    input  logic        copier_ram_cs_n,
    input  logic        copier_eeprom_oe_n,
    input  logic        copier_eeprom_cs_n,
    input  logic [15:0] cpu_address,
    input  logic        cpu_ram_we_n,
    input  logic        cpu_ram_oe_n,
    input  logic        cpu_ram_cs_n,
    output logic        copier_reset_n,
    output logic        cpu_reset_n,
    output logic [15:0] address,
    output logic        ram_we_n,
    output logic        ram_oe_n,
    output logic        ram_cs_n,
    output logic        eeprom_oe_n,
    output logic        eeprom_cs_n,
    output logic        boot_error
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ADDR_W = 16;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(CPU_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(COPY_TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] IDLE_ADDR   = '1;

    typedef enum logic [2:0] {
        ST_RESET_COPIER = 3'd0,
        ST_COPYING      = 3'd1,
        ST_SETTLE       = 3'd2,
        ST_CPU_HOLD     = 3'd3,
        ST_RUNNING      = 3'd4,
        ST_ERROR        = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_count;
    // Set while reset was sampled on the previous edge; keeps RESET_COPIER
    // for one full cycle after reset deasserts so the copier sees a clean pulse.
    logic               r_reset_q;

    // State register, per-state cycle counter and reset-release tracker
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_RESET_COPIER;
            r_count   <= '0;
            r_reset_q <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_count   <= (w_state_next != r_state) ? '0 : r_count + CNT_W'(1);
            r_reset_q <= 1'b0;
        end
    end

    // Next-state selection and combinational decode of the bus/reset outputs
    always_comb begin
        w_state_next   = r_state;
        copier_reset_n = 1'b1;
        cpu_reset_n    = 1'b0;
        boot_error     = 1'b0;
        address        = IDLE_ADDR;
        ram_we_n       = 1'b1;
        ram_oe_n       = 1'b1;
        ram_cs_n       = 1'b1;
        eeprom_oe_n    = 1'b1;
        eeprom_cs_n    = 1'b1;

        case (r_state)
            ST_RESET_COPIER: begin
                copier_reset_n = 1'b0;
                address        = copier_address;
                ram_we_n       = copier_ram_we_n;
                ram_cs_n       = copier_ram_cs_n;
                eeprom_oe_n    = copier_eeprom_oe_n;
                eeprom_cs_n    = copier_eeprom_cs_n;
                if (!r_reset_q) begin
                    w_state_next = ST_COPYING;
                end
            end
            ST_COPYING: begin
                address     = copier_address;
                ram_we_n    = copier_ram_we_n;
                ram_cs_n    = copier_ram_cs_n;
                eeprom_oe_n = copier_eeprom_oe_n;
                eeprom_cs_n = copier_eeprom_cs_n;
                // Completion takes priority over a coincident timeout
                if (copier_done) begin
                    w_state_next = ST_SETTLE;
                end else if (r_count == TIMEOUT_LAST) begin
                    w_state_next = ST_ERROR;
                end
            end
            ST_SETTLE: begin
                if (r_count == SETTLE_LAST) begin
                    w_state_next = ST_CPU_HOLD;
                end
            end
            ST_CPU_HOLD: begin
                address  = cpu_address;
                ram_we_n = cpu_ram_we_n;
                ram_oe_n = cpu_ram_oe_n;
                ram_cs_n = cpu_ram_cs_n;
                if (r_count == HOLD_LAST) begin
                    w_state_next = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                cpu_reset_n = 1'b1;
                address     = cpu_address;
                ram_we_n    = cpu_ram_we_n;
                ram_oe_n    = cpu_ram_oe_n;
                ram_cs_n    = cpu_ram_cs_n;
                if (reboot_req) begin
                    w_state_next = ST_RESET_COPIER;
                end
            end
            ST_ERROR: begin
                boot_error = 1'b1;
                if (reboot_req) begin
                    w_state_next = ST_RESET_COPIER;
                end
            end
            default: begin
                w_state_next = ST_RESET_COPIER;
            end
        endcase
    end

endmodule
